// File: rtl/add_sub_logic_seq.sv
// add_sub_logic_seq: registered WIDTH-bit add/sub/logic unit with valid/ready
// handshakes on both sides, one result register and a sticky carry flag for
// multi-word ADC/SBB chains. Single-cycle latency, one result per cycle.
//
// Optional build macro: ALU_SAT_EN
//   defined   -> ADD/ADC saturate to all-ones on carry, SUB/SBB saturate to
//                zero on borrow; c_flag still takes the raw carry.
//   undefined -> plain modulo-2^WIDTH arithmetic.
module add_sub_logic_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             c_flag,
  output logic             z_flag
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_NOTB = 3'd2;
  localparam logic [2:0] OP_GEU  = 3'd3;
  localparam logic [2:0] OP_ADC  = 3'd4;
  localparam logic [2:0] OP_SBB  = 3'd5;
  localparam logic [2:0] OP_AND  = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  // Architectural state
  logic             valid_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             c_q;
  logic             c_d;
  logic             z_q;

  // Shared adder operands
  logic [WIDTH-1:0] b_eff_s;
  logic             cin_s;
  logic [WIDTH:0]   sum_s;
  logic             carry_s;
  logic             accept_s;

  // No skid buffer: a new bundle may enter only if the result slot is free
  // or being drained in this same cycle.
  assign in_ready = !valid_q || out_ready;
  assign accept_s = in_valid && in_ready;

  // Select the adder's B operand and carry-in for the arithmetic opcodes.
  // ADC/SBB consume the sticky carry as it stands at the accept edge.
  always_comb begin
    b_eff_s = b;
    cin_s   = 1'b0;
    case (op)
      OP_ADD: begin
        b_eff_s = b;
        cin_s   = 1'b0;
      end
      OP_SUB, OP_GEU: begin
        b_eff_s = ~b;
        cin_s   = 1'b1;
      end
      OP_ADC: begin
        b_eff_s = b;
        cin_s   = c_q;
      end
      OP_SBB: begin
        b_eff_s = ~b;
        cin_s   = c_q;
      end
      default: begin
        b_eff_s = b;
        cin_s   = 1'b0;
      end
    endcase
  end

  assign sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
  assign carry_s = sum_s[WIDTH];

  // Next result and next carry; only the four arithmetic ops touch c_flag.
  always_comb begin
    r_d = sum_s[WIDTH-1:0];
    c_d = c_q;
    case (op)
      OP_ADD, OP_ADC: begin
        c_d = carry_s;
`ifdef ALU_SAT_EN
        if (carry_s) begin
          r_d = {WIDTH{1'b1}};
        end else begin
          r_d = sum_s[WIDTH-1:0];
        end
`else
        r_d = sum_s[WIDTH-1:0];
`endif
      end
      OP_SUB, OP_SBB: begin
        c_d = carry_s;
`ifdef ALU_SAT_EN
        if (!carry_s) begin
          r_d = {WIDTH{1'b0}};
        end else begin
          r_d = sum_s[WIDTH-1:0];
        end
`else
        r_d = sum_s[WIDTH-1:0];
`endif
      end
      OP_NOTB: r_d = ~b;
      OP_GEU:  r_d = {{(WIDTH-1){1'b0}}, carry_s};
      OP_AND:  r_d = a & b;
      OP_XOR:  r_d = a ^ b;
      default: begin
        r_d = sum_s[WIDTH-1:0];
        c_d = c_q;
      end
    endcase
  end

  // Result register: load on accept, drop valid when drained without refill,
  // otherwise hold everything stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      r_q     <= {WIDTH{1'b0}};
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else if (accept_s) begin
      valid_q <= 1'b1;
      r_q     <= r_d;
      c_q     <= c_d;
      z_q     <= (r_d == {WIDTH{1'b0}});
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign out_valid = valid_q;
  assign r         = r_q;
  assign c_flag    = c_q;
  assign z_flag    = z_q;

endmodule

// File: tb/tb_add_sub_logic_seq.sv
// Self-checking bench for add_sub_logic_seq (WIDTH=16): directed test-plan
// sequences plus randomized traffic against an integer-arithmetic model.
module tb_add_sub_logic_seq;

  localparam int W = 16;
  localparam longint MODV = 64'd1 << W;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic         c_flag;
  logic         z_flag;

  int total;
  int bad;

  // Reference model state
  logic         m_valid;
  logic [W-1:0] m_r;
  logic         m_c;
  logic         m_z;

  add_sub_logic_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .c_flag(c_flag), .z_flag(z_flag)
  );

  // Free-running clock, 10 time units period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] wrap(input longint v);
    longint t;
    t = v % MODV;
    if (t < 0) t = t + MODV;
    return t[W-1:0];
  endfunction

  // Apply one accepted bundle to the model using plain integer arithmetic.
  task automatic model_apply(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    longint sa;
    longint sb;
    longint v;
    logic   cy;
    logic   arith;
    logic [W-1:0] res;
    sa = longint'(aa);
    sb = longint'(bb);
    arith = 1'b0;
    cy = m_c;
    res = '0;
    case (o)
      3'd0: begin v = sa + sb;                        cy = (v >= MODV); res = wrap(v); arith = 1'b1; end
      3'd1: begin v = sa - sb;                        cy = (v >= 0);    res = wrap(v); arith = 1'b1; end
      3'd2: res = ~bb;
      3'd3: res = (sa >= sb) ? 16'd1 : 16'd0;
      3'd4: begin v = sa + sb + longint'(m_c);        cy = (v >= MODV); res = wrap(v); arith = 1'b1; end
      3'd5: begin v = sa - sb - 1 + longint'(m_c);    cy = (v >= 0);    res = wrap(v); arith = 1'b1; end
      3'd6: res = aa & bb;
      default: res = aa ^ bb;
    endcase
`ifdef ALU_SAT_EN
    if (arith && (o == 3'd0 || o == 3'd4) && cy) res = 16'hffff;
    if (arith && (o == 3'd1 || o == 3'd5) && !cy) res = 16'h0000;
`endif
    m_r = res;
    m_c = cy;
    m_z = (res == 16'h0000);
    m_valid = 1'b1;
  endtask

  // One clock cycle: drive at the falling edge, let the rising edge act,
  // then compare everything at the next falling edge.
  task automatic cycle(input logic iv, input logic [2:0] o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic ordy);
    logic exp_rdy;
    logic acc;
    in_valid = iv; op = o; a = aa; b = bb; out_ready = ordy;
    #1;
    exp_rdy = !m_valid || ordy;
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = iv && exp_rdy;
    @(posedge clk);
    if (acc) model_apply(o, aa, bb);
    else if (ordy) m_valid = 1'b0;
    @(negedge clk);
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("r", 32'(r), 32'(m_r));
    check_eq("c_flag", 32'(c_flag), 32'(m_c));
    check_eq("z_flag", 32'(z_flag), 32'(m_z));
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_r = '0; m_c = 1'b0; m_z = 1'b0;
  endtask

  initial begin
    logic [W-1:0] held_r;
    total = 0; bad = 0;
    model_reset();
    rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; a = '0; b = '0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_r", 32'(r), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mid-stream asynchronous reset with a pending result
    cycle(1'b1, 3'd0, 16'h0007, 16'hffff, 1'b0);
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_r", 32'(r), 32'd0);
    check_eq("async_rst_c", 32'(c_flag), 32'd0);
    check_eq("async_rst_z", 32'(z_flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic ADD
    cycle(1'b1, 3'd0, 16'd2, 16'd3, 1'b1);
    check_eq("add_r", 32'(r), 32'd5);
    check_eq("add_c", 32'(c_flag), 32'd0);
    check_eq("add_z", 32'(z_flag), 32'd0);

    // SUB / GEU / NOTB
    cycle(1'b1, 3'd1, 16'd100, 16'd200, 1'b1);
`ifdef ALU_SAT_EN
    check_eq("sub_r", 32'(r), 32'h0000);
`else
    check_eq("sub_r", 32'(r), 32'hff9c);
`endif
    check_eq("sub_c", 32'(c_flag), 32'd0);
    cycle(1'b1, 3'd3, 16'd10, 16'd3, 1'b1);
    check_eq("geu_1", 32'(r), 32'd1);
    cycle(1'b1, 3'd3, 16'd3, 16'd10, 1'b1);
    check_eq("geu_0", 32'(r), 32'd0);
    cycle(1'b1, 3'd2, 16'd0, 16'd11, 1'b1);
    check_eq("notb", 32'(r), 32'hfff4);

    // Multi-word chain
    cycle(1'b1, 3'd0, 16'hffff, 16'h0001, 1'b1);
`ifdef ALU_SAT_EN
    check_eq("chain_add_r", 32'(r), 32'hffff);
`else
    check_eq("chain_add_r", 32'(r), 32'h0000);
    check_eq("chain_add_z", 32'(z_flag), 32'd1);
`endif
    check_eq("chain_add_c", 32'(c_flag), 32'd1);
    cycle(1'b1, 3'd4, 16'h0000, 16'h0000, 1'b1);
    check_eq("chain_adc_r", 32'(r), 32'd1);
    check_eq("chain_adc_c", 32'(c_flag), 32'd0);
    cycle(1'b1, 3'd1, 16'h0000, 16'h0001, 1'b1);
    check_eq("chain_sub_c", 32'(c_flag), 32'd0);
    cycle(1'b1, 3'd5, 16'd5, 16'd2, 1'b1);
    check_eq("chain_sbb_r", 32'(r), 32'd2);
    check_eq("chain_sbb_c", 32'(c_flag), 32'd1);

    // Saturation-sensitive pair
    cycle(1'b1, 3'd0, 16'hff00, 16'h0200, 1'b1);
`ifdef ALU_SAT_EN
    check_eq("satadd_r", 32'(r), 32'hffff);
`else
    check_eq("satadd_r", 32'(r), 32'h0100);
`endif
    check_eq("satadd_c", 32'(c_flag), 32'd1);
    cycle(1'b1, 3'd1, 16'h0003, 16'h0005, 1'b1);
`ifdef ALU_SAT_EN
    check_eq("satsub_r", 32'(r), 32'h0000);
    check_eq("satsub_z", 32'(z_flag), 32'd1);
`else
    check_eq("satsub_r", 32'(r), 32'hfffe);
    check_eq("satsub_z", 32'(z_flag), 32'd0);
`endif
    check_eq("satsub_c", 32'(c_flag), 32'd0);

    // Backpressure: fill the slot, then stall a waiting bundle for 3 cycles
    cycle(1'b1, 3'd6, 16'hf0f0, 16'h3c3c, 1'b0);
    held_r = r;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 3'd7, 16'h1234, 16'h00ff, 1'b0);
      check_eq("stall_r", 32'(r), 32'(held_r));
    end
    cycle(1'b1, 3'd7, 16'h1234, 16'h00ff, 1'b1);
    check_eq("unstall_r", 32'(r), 32'h12cb);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 3'd0, 16'(i * 16'd100), 16'd1, 1'b1);
      check_eq("stream_r", 32'(r), 32'(i * 100 + 1));
      check_eq("stream_valid", 32'(out_valid), 32'd1);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'hffff;
      if ($urandom_range(0, 7) == 0) rb = 16'h0000;
      if ($urandom_range(0, 9) == 0) rb = ra;
      cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), ra, rb,
            1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
